// File: rtl/rank_order_encoder_ctrl.sv
// rank_order_encoder_ctrl
//   Rank-order (intensity-first) scheduler. Sweeps intensity from
//   PIXEL_MAX_VALUE down to 0 and, at each level, scans every pixel of the
//   image buffer. Each pixel whose value equals the current level is sent
//   out as one AER event using a 4-phase REQ/ACK handshake.
//
// Ports
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   NEW_IMAGE       start pulse, sampled only while idle
//   PIX_RD/PIX_ADDR image buffer read strobe and address
//   PIX_DATA        read data, valid the cycle after PIX_RD
//   AEROUT_ADDR     emitted pixel index
//   AEROUT_REQ/ACK  AER handshake (ACK already synchronised)
//   BUSY            high whenever the scheduler is not idle
//   IMAGE_ENCODED   one-cycle pulse when the image is finished
//   EVENT_COUNT     events emitted for the current/last image
module rank_order_encoder_ctrl #(
  parameter int IMAGE_SIZE      = 16,
  parameter int PIXEL_MAX_VALUE = 15,
  parameter int ADDR_BITS       = $clog2(IMAGE_SIZE),
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE + 1)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   NEW_IMAGE,
  output logic                   PIX_RD,
  output logic [ADDR_BITS-1:0]   PIX_ADDR,
  input  logic [PIXEL_BITS-1:0]  PIX_DATA,
  output logic [ADDR_BITS-1:0]   AEROUT_ADDR,
  output logic                   AEROUT_REQ,
  input  logic                   AEROUT_ACK,
  output logic                   BUSY,
  output logic                   IMAGE_ENCODED,
  output logic [ADDR_BITS:0]     EVENT_COUNT
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_CMP    = 3'd2;
  localparam logic [2:0] S_REQ_HI = 3'd3;
  localparam logic [2:0] S_REQ_LO = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [ADDR_BITS-1:0]  LAST_ADDR = ADDR_BITS'(IMAGE_SIZE - 1);
  localparam logic [PIXEL_BITS-1:0] MAX_INT   = PIXEL_BITS'(PIXEL_MAX_VALUE);
  localparam logic [ADDR_BITS:0]    FULL_CNT  = (ADDR_BITS+1)'(IMAGE_SIZE);

  logic [2:0]            r_state;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [PIXEL_BITS-1:0] r_int;
  logic [ADDR_BITS-1:0]  r_aer_addr;
  logic [ADDR_BITS:0]    r_cnt;

  logic                  w_last_addr;
  logic                  w_sweep_end;
  logic                  w_match;
  logic [ADDR_BITS:0]    w_cnt_inc;

  assign w_last_addr = (r_addr == LAST_ADDR);
  // Last pixel of the level-0 scan: nothing is left to visit. Also the only
  // point where a decrement could underflow, so advancing is blocked here.
  assign w_sweep_end = w_last_addr && (r_int == '0);
  assign w_match     = (PIX_DATA == r_int);
  assign w_cnt_inc   = r_cnt + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_int      <= MAX_INT;
      r_aer_addr <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (NEW_IMAGE) begin
            r_int   <= MAX_INT;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_state <= S_READ;
          end
        end
        S_READ: r_state <= S_CMP;
        S_CMP: begin
          if (w_match) begin
            r_aer_addr <= r_addr;
            r_state    <= S_REQ_HI;
          end else if (w_sweep_end) begin
            r_state <= S_DONE;
          end else begin
            if (w_last_addr) begin
              r_addr <= '0;
              r_int  <= r_int - 1'b1;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
            r_state <= S_READ;
          end
        end
        // REQ is decoded from this state, so it is high for at least one
        // cycle even when ACK is already high on entry.
        S_REQ_HI: begin
          if (AEROUT_ACK) r_state <= S_REQ_LO;
        end
        S_REQ_LO: begin
          if (!AEROUT_ACK) begin
            r_cnt <= w_cnt_inc;
            // Every pixel emitted: stop early without further reads.
            if (w_cnt_inc == FULL_CNT || w_sweep_end) begin
              r_state <= S_DONE;
            end else begin
              if (w_last_addr) begin
                r_addr <= '0;
                r_int  <= r_int - 1'b1;
              end else begin
                r_addr <= r_addr + 1'b1;
              end
              r_state <= S_READ;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign PIX_RD        = (r_state == S_READ);
  assign PIX_ADDR      = r_addr;
  assign AEROUT_ADDR   = r_aer_addr;
  assign AEROUT_REQ    = (r_state == S_REQ_HI);
  assign BUSY          = (r_state != S_IDLE);
  assign IMAGE_ENCODED = (r_state == S_DONE);
  assign EVENT_COUNT   = r_cnt;

endmodule

// File: tb/tb_rank_order_encoder_ctrl.sv
// Bench for rank_order_encoder_ctrl: 6-pixel image, max level 5, 3-bit pixel
// values so levels 6/7 exist but are never emitted. A synchronous image
// memory and an AER receiver with programmable ACK timing surround the DUT.
module tb_rank_order_encoder_ctrl;
  localparam int N    = 6;
  localparam int MAXV = 5;
  localparam int AB   = 3;
  localparam int PB   = 3;

  logic          CLK = 0;
  logic          RST = 1;
  logic          NEW_IMAGE = 0;
  logic          PIX_RD;
  logic [AB-1:0] PIX_ADDR;
  logic [PB-1:0] PIX_DATA = '0;
  logic [AB-1:0] AEROUT_ADDR;
  logic          AEROUT_REQ;
  logic          AEROUT_ACK = 0;
  logic          BUSY;
  logic          IMAGE_ENCODED;
  logic [AB:0]   EVENT_COUNT;

  rank_order_encoder_ctrl #(.IMAGE_SIZE(N), .PIXEL_MAX_VALUE(MAXV),
                            .ADDR_BITS(AB), .PIXEL_BITS(PB)) dut (
    .CLK(CLK), .RST(RST), .NEW_IMAGE(NEW_IMAGE), .PIX_RD(PIX_RD),
    .PIX_ADDR(PIX_ADDR), .PIX_DATA(PIX_DATA), .AEROUT_ADDR(AEROUT_ADDR),
    .AEROUT_REQ(AEROUT_REQ), .AEROUT_ACK(AEROUT_ACK), .BUSY(BUSY),
    .IMAGE_ENCODED(IMAGE_ENCODED), .EVENT_COUNT(EVENT_COUNT));

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // image memory with one-cycle read latency
  logic [PB-1:0] img [N];
  always @(posedge CLK) if (PIX_RD) PIX_DATA <= img[PIX_ADDR];

  // AER receiver
  int ack_delay  = 0;
  bit rand_ack   = 0;
  bit early_mode = 0;
  int ack_wait   = 0;
  bit resp_prev  = 0;
  initial forever begin
    @(negedge CLK);
    if (RST) begin
      AEROUT_ACK = 0; ack_wait = 0;
    end else if (early_mode) begin
      // ACK drops only for the cycle right after REQ falls, so it is
      // already high whenever a new request starts.
      AEROUT_ACK = !(resp_prev && !AEROUT_REQ);
    end else if (AEROUT_REQ) begin
      if (!AEROUT_ACK) begin
        if (ack_wait >= ack_delay) AEROUT_ACK = 1;
        else ack_wait++;
      end
    end else begin
      AEROUT_ACK = 0; ack_wait = 0;
      if (rand_ack) ack_delay = $urandom_range(0, 3);
    end
    resp_prev = AEROUT_REQ;
  end

  // monitor
  int          ev_q[$];
  int          rd_cnt = 0, enc_cnt = 0, stable_err = 0, req_len = 0, max_req_len = 0;
  bit          mon_prev = 0;
  logic [AB-1:0] hold_addr = '0;
  always @(negedge CLK) begin
    if (PIX_RD) rd_cnt++;
    if (IMAGE_ENCODED) enc_cnt++;
    if (AEROUT_REQ && !mon_prev) begin
      ev_q.push_back(int'(AEROUT_ADDR)); hold_addr = AEROUT_ADDR; req_len = 0;
    end
    if (AEROUT_REQ) begin
      req_len++;
      if (req_len > max_req_len) max_req_len = req_len;
      if (AEROUT_ADDR !== hold_addr || PIX_ADDR !== AEROUT_ADDR || BUSY !== 1'b1) stable_err++;
    end else if (!early_mode && AEROUT_ACK && BUSY && AEROUT_ADDR !== hold_addr) begin
      stable_err++;
    end
    mon_prev = AEROUT_REQ;
  end

  task automatic clear_mon();
    ev_q.delete(); rd_cnt = 0; enc_cnt = 0; stable_err = 0; max_req_len = 0;
  endtask

  // Starts one image, waits for completion and compares with the reference:
  // events in (descending level, ascending address) order, stopping as soon
  // as every pixel has been emitted; one read per pixel visited.
  task automatic run_and_check(input string nm, input bit extra_starts);
    int exp_ev[$];
    int exp_rd = 0;
    int cyc = 0;
    bit ok;
    string sg, se;
    for (int v = MAXV; v >= 0 && exp_ev.size() < N; v--)
      for (int a = 0; a < N && exp_ev.size() < N; a++) begin
        exp_rd++;
        if (int'(img[a]) == v) exp_ev.push_back(a);
      end
    clear_mon();
    @(negedge CLK); NEW_IMAGE = 1;
    @(negedge CLK); NEW_IMAGE = 0;
    while (!IMAGE_ENCODED && cyc < 5000) begin
      NEW_IMAGE = extra_starts && (cyc % 7 == 3);
      @(negedge CLK); cyc++;
    end
    NEW_IMAGE = 0;
    tests++;
    if (cyc >= 5000) begin
      fails++; $display("FAIL %s timeout: no IMAGE_ENCODED within %0d cycles", nm, cyc);
    end
    repeat (5) @(negedge CLK);
    ok = (ev_q.size() == exp_ev.size());
    for (int i = 0; ok && i < exp_ev.size(); i++) if (ev_q[i] != exp_ev[i]) ok = 0;
    sg = ""; se = "";
    foreach (ev_q[i]) sg = {sg, $sformatf("%0d ", ev_q[i])};
    foreach (exp_ev[i]) se = {se, $sformatf("%0d ", exp_ev[i])};
    tests++;
    if (!ok) begin fails++; $display("FAIL %s events: got [%s] expected [%s]", nm, sg, se); end
    tests++;
    if (rd_cnt != exp_rd) begin fails++; $display("FAIL %s reads: got %0d expected %0d", nm, rd_cnt, exp_rd); end
    tests++;
    if (EVENT_COUNT !== (AB+1)'(exp_ev.size())) begin
      fails++; $display("FAIL %s event_count: got %0d expected %0d", nm, EVENT_COUNT, exp_ev.size());
    end
    tests++;
    if (enc_cnt != 1) begin fails++; $display("FAIL %s encoded_pulses: got %0d expected 1", nm, enc_cnt); end
    tests++;
    if (stable_err != 0) begin fails++; $display("FAIL %s handshake_stability: got %0d errors expected 0", nm, stable_err); end
    tests++;
    if (BUSY !== 1'b0) begin fails++; $display("FAIL %s busy_after_done: got %b expected 0", nm, BUSY); end
  endtask

  task automatic set_img(input int a0, a1, a2, a3, a4, a5);
    img[0] = PB'(a0); img[1] = PB'(a1); img[2] = PB'(a2);
    img[3] = PB'(a3); img[4] = PB'(a4); img[5] = PB'(a5);
  endtask

  task automatic test_reset();
    RST = 1;
    repeat (2) @(negedge CLK);
    tests++;
    if ({PIX_RD, PIX_ADDR, AEROUT_ADDR, AEROUT_REQ, BUSY, IMAGE_ENCODED, EVENT_COUNT} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: rd=%b paddr=%0d aaddr=%0d req=%b busy=%b enc=%b cnt=%0d expected all 0",
               PIX_RD, PIX_ADDR, AEROUT_ADDR, AEROUT_REQ, BUSY, IMAGE_ENCODED, EVENT_COUNT);
    end
    RST = 0;
    @(negedge CLK);
  endtask

  task automatic test_directed();
    ack_delay = 1; rand_ack = 0;
    set_img(1, 5, 0, 5, 7, 6); run_and_check("mixed_sweep_end", 0);
    set_img(5, 5, 5, 5, 5, 5); run_and_check("all_max_early", 0);
    set_img(7, 7, 6, 7, 6, 7); run_and_check("none_emitted", 0);
    set_img(0, 1, 2, 3, 4, 5); run_and_check("one_per_level", 0);
  endtask

  task automatic test_random();
    rand_ack = 1;
    for (int k = 0; k < 20; k++) begin
      for (int a = 0; a < N; a++) img[a] = PB'($urandom_range(0, 7));
      run_and_check($sformatf("random_%0d", k), 0);
    end
    rand_ack = 0;
  endtask

  task automatic test_ack_stall();
    ack_delay = 20;
    set_img(0, 0, 5, 0, 0, 0);
    run_and_check("ack_stall", 0);
    tests++;
    if (max_req_len != 21) begin fails++; $display("FAIL ack_stall_req_len: got %0d expected 21", max_req_len); end
    ack_delay = 1;
  endtask

  task automatic test_ack_early();
    early_mode = 1;
    set_img(2, 4, 2, 0, 6, 4);
    run_and_check("ack_early", 0);
    tests++;
    if (max_req_len != 1) begin fails++; $display("FAIL ack_early_req_len: got %0d expected 1", max_req_len); end
    early_mode = 0;
    @(negedge CLK);
  endtask

  task automatic test_new_image_ignored();
    ack_delay = 2;
    set_img(3, 1, 3, 6, 0, 1);
    run_and_check("new_image_ignored", 1);
    ack_delay = 1;
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    ack_delay = 3;
    set_img(4, 4, 4, 4, 4, 4);
    clear_mon();
    @(negedge CLK); NEW_IMAGE = 1;
    @(negedge CLK); NEW_IMAGE = 0;
    while (!(EVENT_COUNT == 2 && AEROUT_REQ) && cyc < 2000) begin @(negedge CLK); cyc++; end
    tests++;
    if (cyc >= 2000) begin fails++; $display("FAIL reset_mid_reach: timeout waiting for 3rd request"); end
    RST = 1;
    #1;
    tests++;
    if ({AEROUT_REQ, BUSY, EVENT_COUNT} !== '0) begin
      fails++; $display("FAIL reset_mid_async: req=%b busy=%b cnt=%0d expected 0 0 0", AEROUT_REQ, BUSY, EVENT_COUNT);
    end
    enc_cnt = 0;
    repeat (3) @(negedge CLK);
    RST = 0;
    repeat (3) @(negedge CLK);
    tests++;
    if (enc_cnt != 0) begin fails++; $display("FAIL reset_mid_no_pulse: got %0d pulses expected 0", enc_cnt); end
    ack_delay = 1;
    set_img(2, 5, 1, 5, 3, 0);
    run_and_check("restart_after_reset", 0);
  endtask

  initial begin
    for (int a = 0; a < N; a++) img[a] = '0;
    test_reset();
    test_directed();
    test_random();
    test_ack_stall();
    test_ack_early();
    test_new_image_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
